// File: rtl/bus_drvr_fifo_port.sv
// bus_drvr_fifo_port: driver-slot endpoint of the bus FIFO interface.
// TX queue is filled by the host and drained by the bus (pndng/pop/D_pop);
// RX queue is filled by the bus (push/D_push) and drained by the host.
// Optional destination-ID filter on RX: define BUS_PORT_ID_FILTER_EN.
module bus_drvr_fifo_port #(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  id        = 8'd0,
  parameter logic [7:0]  broadcast = {8{1'b1}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tx_push,
  input  logic [pckg_sz-1:0]           tx_data,
  output logic                         tx_full,
  output logic [$clog2(depth+1)-1:0]   tx_count,
  output logic                         pndng,
  input  logic                         pop,
  output logic [pckg_sz-1:0]           D_pop,
  input  logic                         push,
  input  logic [pckg_sz-1:0]           D_push,
  output logic                         rx_pndng,
  input  logic                         rx_pop,
  output logic [pckg_sz-1:0]           rx_data,
  output logic [$clog2(depth+1)-1:0]   rx_count,
  output logic                         tx_overflow,
  output logic                         rx_overflow,
  output logic [7:0]                   misroute_cnt
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = $clog2(depth + 1);

  // ---------------- TX queue ----------------
  logic [pckg_sz-1:0] r_tx_mem [depth];
  logic [AW-1:0]      r_tx_wr_ptr;
  logic [AW-1:0]      r_tx_rd_ptr;
  logic [CW-1:0]      r_tx_count;
  logic               r_tx_overflow;
  logic               w_tx_rd;
  logic               w_tx_wr;

  // A full queue always has a valid head, so a same-cycle pop frees a slot
  assign w_tx_rd = pop && (r_tx_count != '0);
  assign w_tx_wr = tx_push && (!tx_full || w_tx_rd);

  // TX pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_wr_ptr   <= '0;
      r_tx_rd_ptr   <= '0;
      r_tx_count    <= '0;
      r_tx_overflow <= 1'b0;
    end else begin
      if (w_tx_wr) r_tx_wr_ptr <= r_tx_wr_ptr + AW'(1);
      if (w_tx_rd) r_tx_rd_ptr <= r_tx_rd_ptr + AW'(1);
      case ({w_tx_wr, w_tx_rd})
        2'b10:   r_tx_count <= r_tx_count + CW'(1);
        2'b01:   r_tx_count <= r_tx_count - CW'(1);
        default: r_tx_count <= r_tx_count;
      endcase
      if (tx_push && !w_tx_wr) r_tx_overflow <= 1'b1;
    end
  end

  // TX storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (w_tx_wr) r_tx_mem[r_tx_wr_ptr] <= tx_data;
  end

  assign tx_count    = r_tx_count;
  assign tx_full     = (r_tx_count == CW'(depth));
  assign pndng       = (r_tx_count != '0);
  assign D_pop       = pndng ? r_tx_mem[r_tx_rd_ptr] : '0;
  assign tx_overflow = r_tx_overflow;

  // ---------------- RX filter ----------------
  logic [7:0] w_dest;
  logic       w_id_hit;
  logic       w_match;

  assign w_dest   = D_push[pckg_sz-1 -: 8];
  assign w_id_hit = (w_dest == id) || (w_dest == broadcast);

`ifdef BUS_PORT_ID_FILTER_EN
  logic [7:0] r_misroute_cnt;

  assign w_match = w_id_hit;

  // Saturating count of packets rejected by the ID filter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misroute_cnt <= 8'd0;
    end else if (push && !w_match && (r_misroute_cnt != 8'hFF)) begin
      r_misroute_cnt <= r_misroute_cnt + 8'd1;
    end
  end

  assign misroute_cnt = r_misroute_cnt;
`else
  // Filter bypassed: every push is addressed to this endpoint
  assign w_match      = w_id_hit | 1'b1;
  assign misroute_cnt = 8'd0;
`endif

  // ---------------- RX queue ----------------
  logic [pckg_sz-1:0] r_rx_mem [depth];
  logic [AW-1:0]      r_rx_wr_ptr;
  logic [AW-1:0]      r_rx_rd_ptr;
  logic [CW-1:0]      r_rx_count;
  logic               r_rx_overflow;
  logic               w_rx_req;
  logic               w_rx_rd;
  logic               w_rx_wr;
  logic               w_rx_full;

  assign w_rx_full = (r_rx_count == CW'(depth));
  assign w_rx_req  = push && w_match;
  assign w_rx_rd   = rx_pop && (r_rx_count != '0);
  assign w_rx_wr   = w_rx_req && (!w_rx_full || w_rx_rd);

  // RX pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_wr_ptr   <= '0;
      r_rx_rd_ptr   <= '0;
      r_rx_count    <= '0;
      r_rx_overflow <= 1'b0;
    end else begin
      if (w_rx_wr) r_rx_wr_ptr <= r_rx_wr_ptr + AW'(1);
      if (w_rx_rd) r_rx_rd_ptr <= r_rx_rd_ptr + AW'(1);
      case ({w_rx_wr, w_rx_rd})
        2'b10:   r_rx_count <= r_rx_count + CW'(1);
        2'b01:   r_rx_count <= r_rx_count - CW'(1);
        default: r_rx_count <= r_rx_count;
      endcase
      if (w_rx_req && !w_rx_wr) r_rx_overflow <= 1'b1;
    end
  end

  // RX storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (w_rx_wr) r_rx_mem[r_rx_wr_ptr] <= D_push;
  end

  assign rx_count    = r_rx_count;
  assign rx_pndng    = (r_rx_count != '0);
  assign rx_data     = rx_pndng ? r_rx_mem[r_rx_rd_ptr] : '0;
  assign rx_overflow = r_rx_overflow;

endmodule

// File: tb/tb_bus_drvr_fifo_port.sv
// Directed bench for bus_drvr_fifo_port (endpoint id = 2).
module tb_bus_drvr_fifo_port;

  logic        clk;
  logic        reset;
  logic        tx_push;
  logic [15:0] tx_data;
  logic        tx_full;
  logic [3:0]  tx_count;
  logic        pndng;
  logic        pop;
  logic [15:0] D_pop;
  logic        push;
  logic [15:0] D_push;
  logic        rx_pndng;
  logic        rx_pop;
  logic [15:0] rx_data;
  logic [3:0]  rx_count;
  logic        tx_overflow;
  logic        rx_overflow;
  logic [7:0]  misroute_cnt;

  int checks = 0;
  int errors = 0;

  bus_drvr_fifo_port #(
    .pckg_sz(16), .depth(8), .id(8'h02), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full), .tx_count(tx_count),
    .pndng(pndng), .pop(pop), .D_pop(D_pop),
    .push(push), .D_push(D_push),
    .rx_pndng(rx_pndng), .rx_pop(rx_pop), .rx_data(rx_data), .rx_count(rx_count),
    .tx_overflow(tx_overflow), .rx_overflow(rx_overflow), .misroute_cnt(misroute_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_tx_count"}, 32'(tx_count), 32'd0);
    check_eq({tag, "_rx_count"}, 32'(rx_count), 32'd0);
    check_eq({tag, "_pndng"}, 32'(pndng), 32'd0);
    check_eq({tag, "_rx_pndng"}, 32'(rx_pndng), 32'd0);
    check_eq({tag, "_tx_full"}, 32'(tx_full), 32'd0);
    check_eq({tag, "_D_pop"}, 32'(D_pop), 32'd0);
    check_eq({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check_eq({tag, "_tx_ovf"}, 32'(tx_overflow), 32'd0);
    check_eq({tag, "_rx_ovf"}, 32'(rx_overflow), 32'd0);
    check_eq({tag, "_misroute"}, 32'(misroute_cnt), 32'd0);
  endtask

  initial begin
    logic [15:0] exp_q [8];
    reset = 1'b0; tx_push = 1'b0; tx_data = '0; pop = 1'b0;
    push = 1'b0; D_push = '0; rx_pop = 1'b0;

    // Reset state
    repeat (3) tick();
    check_idle("rst");
    reset = 1'b1;
    tick();

    // Basic TX ordering
    tx_push = 1'b1; tx_data = 16'h0111; tick();
    tx_data = 16'h0222; tick();
    tx_data = 16'h0333; tick();
    tx_push = 1'b0;
    check_eq("tx3_count", 32'(tx_count), 32'd3);
    check_eq("tx3_head", 32'(D_pop), 32'h0111);
    check_eq("tx3_pndng", 32'(pndng), 32'd1);
    pop = 1'b1; tick();
    check_eq("tx_pop1", 32'(D_pop), 32'h0222);
    tick();
    check_eq("tx_pop2", 32'(D_pop), 32'h0333);
    tick();
    pop = 1'b0;
    check_eq("tx_empty_pndng", 32'(pndng), 32'd0);
    check_eq("tx_empty_dpop", 32'(D_pop), 32'd0);
    check_eq("tx_empty_count", 32'(tx_count), 32'd0);

    // Pop while empty is ignored
    pop = 1'b1; tick(); pop = 1'b0;
    check_eq("tx_pop_empty", 32'(tx_count), 32'd0);

    // TX full / overflow
    for (int i = 0; i < 8; i++) begin
      tx_push = 1'b1; tx_data = 16'h1000 + 16'(i); tick();
    end
    tx_push = 1'b0;
    check_eq("tx_full", 32'(tx_full), 32'd1);
    check_eq("tx_full_count", 32'(tx_count), 32'd8);
    check_eq("tx_no_ovf_yet", 32'(tx_overflow), 32'd0);
    tx_push = 1'b1; tx_data = 16'h0A0A; tick(); tx_push = 1'b0;
    check_eq("tx_ovf", 32'(tx_overflow), 32'd1);
    check_eq("tx_ovf_count", 32'(tx_count), 32'd8);
    check_eq("tx_ovf_head", 32'(D_pop), 32'h1000);
    tx_push = 1'b1; pop = 1'b1; tx_data = 16'h0A0A; tick();
    tx_push = 1'b0;
    check_eq("tx_pushpop_count", 32'(tx_count), 32'd8);
    check_eq("tx_pushpop_head", 32'(D_pop), 32'h1001);
    for (int i = 0; i < 7; i++) exp_q[i] = 16'h1001 + 16'(i);
    exp_q[7] = 16'h0A0A;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("tx_drain%0d", i), 32'(D_pop), 32'(exp_q[i]));
      tick();
    end
    pop = 1'b0;
    check_eq("tx_drained", 32'(pndng), 32'd0);
    check_eq("tx_ovf_sticky", 32'(tx_overflow), 32'd1);

    // RX destination filter
    push = 1'b1; D_push = 16'h02AB; tick();
    D_push = 16'hFFCD; tick();
    D_push = 16'h05EF; tick();
    push = 1'b0;
`ifdef BUS_PORT_ID_FILTER_EN
    check_eq("rx_filt_count", 32'(rx_count), 32'd2);
    check_eq("rx_misroute", 32'(misroute_cnt), 32'd1);
`else
    check_eq("rx_filt_count", 32'(rx_count), 32'd3);
    check_eq("rx_misroute", 32'(misroute_cnt), 32'd0);
`endif
    check_eq("rx_head0", 32'(rx_data), 32'h02AB);
    rx_pop = 1'b1; tick();
    check_eq("rx_head1", 32'(rx_data), 32'hFFCD);
    tick();
`ifndef BUS_PORT_ID_FILTER_EN
    check_eq("rx_head2", 32'(rx_data), 32'h05EF);
    tick();
`endif
    rx_pop = 1'b0;
    check_eq("rx_empty", 32'(rx_pndng), 32'd0);
    check_eq("rx_empty_data", 32'(rx_data), 32'd0);

    // RX full / overflow
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; D_push = 16'h0210 + 16'(i); tick();
    end
    push = 1'b0;
    check_eq("rx_full_count", 32'(rx_count), 32'd8);
    push = 1'b1; D_push = 16'h0201; tick(); push = 1'b0;
    check_eq("rx_ovf", 32'(rx_overflow), 32'd1);
    check_eq("rx_ovf_count", 32'(rx_count), 32'd8);
    check_eq("rx_ovf_head", 32'(rx_data), 32'h0210);
    push = 1'b1; rx_pop = 1'b1; D_push = 16'h0202; tick();
    push = 1'b0;
    check_eq("rx_pushpop_count", 32'(rx_count), 32'd8);
    for (int i = 0; i < 7; i++) exp_q[i] = 16'h0211 + 16'(i);
    exp_q[7] = 16'h0202;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("rx_drain%0d", i), 32'(rx_data), 32'(exp_q[i]));
      tick();
    end
    rx_pop = 1'b0;
    check_eq("rx_drained", 32'(rx_pndng), 32'd0);

    // Write and read together on empty RX
    push = 1'b1; rx_pop = 1'b1; D_push = 16'h0203; tick();
    push = 1'b0; rx_pop = 1'b0;
    check_eq("rx_wr_rd_empty_cnt", 32'(rx_count), 32'd1);
    check_eq("rx_wr_rd_empty_pnd", 32'(rx_pndng), 32'd1);
    check_eq("rx_wr_rd_empty_dat", 32'(rx_data), 32'h0203);

    // Half-fill both queues, then reset asynchronously mid-stream
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; D_push = 16'h0230 + 16'(i);
      tx_push = 1'b1; tx_data = 16'h0500 + 16'(i); tick();
    end
    tx_data = 16'h0503; push = 1'b0; tick();
    tx_push = 1'b0;
    check_eq("mid_tx_count", 32'(tx_count), 32'd4);
    check_eq("mid_rx_count", 32'(rx_count), 32'd4);
    #2 reset = 1'b0;
    #1;
    check_idle("async_rst");
    tick();
    reset = 1'b1;
    tick();
    tx_push = 1'b1; tx_data = 16'h0777; tick(); tx_push = 1'b0;
    check_eq("post_rst_head", 32'(D_pop), 32'h0777);
    check_eq("post_rst_count", 32'(tx_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_drvr_fifo_port.md
# bus_drvr_fifo_port

Device-side endpoint of the bus generator/arbiter FIFO interface: one instance per driver slot. It holds a transmit queue that the bus drains through `pndng`/`pop`/`D_pop`, and a receive queue that the bus fills through `push`/`D_push`. Its host side gives a simple push/pop FIFO interface to the local agent. It also filters received packets by destination ID and keeps sticky error flags.

## Interface
- `pckg_sz`, 16: packet width in bits; bits `[pckg_sz-1:pckg_sz-8]` are the destination ID.
- `depth`, 8: entries per queue; power of two, ≥2.
- `id`, 0: this endpoint's 8-bit ID.
- `broadcast`, {8{1'b1}}: destination ID accepted by every endpoint.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_push`  in  1  host writes `tx_data` into the TX queue.
- `tx_data`  in  pckg_sz  host packet to send.
- `tx_full`  out  1  TX queue holds `depth` entries.
- `tx_count`  out  $clog2(depth+1)  TX occupancy.
- `pndng`  out  1  TX queue non-empty (to bus).
- `pop`  in  1  bus consumes TX head.
- `D_pop`  out  pckg_sz  TX head packet; 0 when `pndng`=0.
- `push`  in  1  bus delivers `D_push`.
- `D_push`  in  pckg_sz  packet from bus.
- `rx_pndng`  out  1  RX queue non-empty.
- `rx_pop`  in  1  host consumes RX head.
- `rx_data`  out  pckg_sz  RX head packet; 0 when `rx_pndng`=0.
- `rx_count`  out  $clog2(depth+1)  RX occupancy.
- `tx_overflow`  out  1  sticky: `tx_push` while full and not popped.
- `rx_overflow`  out  1  sticky: accepted packet dropped because RX full.
- `misroute_cnt`  out  8  saturating count of packets dropped by the ID filter.

## Operation
- Both queues are first-word-fall-through circular buffers. Each has read and write pointers of width $clog2(depth) that wrap at `depth`, and a separate occupancy counter.
- TX write: `tx_push` && (!`tx_full` || `pop`) writes the packet. `tx_push` while full without `pop` drops the packet and sets `tx_overflow`.
- TX read: `pop` && `pndng` advances the head. `pop` while empty is ignored with no state change.
- RX accept: `push` with destination == `id` or == `broadcast` (filter, see Configuration).
  - Written if !full, or if full and `rx_pop` is asserted in the same cycle.
  - Otherwise dropped and `rx_overflow` set.
- RX filter reject: packet is dropped and `misroute_cnt` increments, saturating at 255.
- RX read: `rx_pop` && `rx_pndng` advances the head. `rx_pop` while empty is ignored.
- Simultaneous write and read on a non-empty queue: occupancy is unchanged and both pointers advance.
- Simultaneous write and read on an empty queue: the write lands and the read is ignored, so occupancy becomes 1.
- Sticky flags and `misroute_cnt` clear only on reset.

## Timing
- Reset (async assert, sync-safe deassert) forces: pointers and counts to 0; `pndng`, `rx_pndng`, `tx_full` to 0; `D_pop`, `rx_data` to 0; `tx_overflow`, `rx_overflow` to 0; `misroute_cnt` to 0. Queue contents are don't-care.
- Latency: a write at edge N makes the packet visible on `D_pop`/`rx_data`, with `pndng`/`rx_pndng` high, after edge N (cycle N+1). Push-to-pop minimum is 1 cycle.
- `D_pop`, `rx_data`, flags and counts are driven from registered state only, with no combinational path from any input.
- Reset asserted mid-transfer discards all queued packets immediately. The first write after release is the head.

## Configuration
- `BUS_PORT_ID_FILTER_EN`
  - Defined: destination filtering as described above.
  - Undefined: every `push` is treated as addressed to this endpoint, and `misroute_cnt` is tied to 0.

## Test plan
- Reset, then 3 `tx_push` of 16'h0111, 16'h0222, 16'h0333 -> `tx_count`=3, `D_pop`=16'h0111. Three `pop`s return the packets in order, then `pndng`=0 and `D_pop`=0.
- Fill TX with 8 packets, then `tx_push` 16'h0A0A with no `pop` -> `tx_full`=1, `tx_overflow`=1, and the packet is not stored. Repeat with `pop` asserted in the same cycle -> packet accepted, `tx_count` stays 8.
- `id`=2: push 16'h02AB, 16'hFFCD, 16'h05EF -> `rx_count`=2, `rx_data` shows 16'h02AB then 16'hFFCD, `misroute_cnt`=1. With the macro undefined -> `rx_count`=3.
- RX full (8 entries): `push` 16'h0201 alone -> dropped, `rx_overflow`=1. `push` 16'h0202 with `rx_pop` -> accepted as tail, `rx_count`=8.
- Empty RX: `push` and `rx_pop` in the same cycle -> `rx_count`=1, `rx_pndng`=1 next cycle.
- Assert `reset` low mid-stream with both queues half full -> all outputs 0 asynchronously. After release, `tx_push` 16'h0777 -> `D_pop`=16'h0777.
